// File: rtl/ahb_blockram_if_pkg.sv
// Shared AHB-Lite encodings and the byte-lane decode used by the block-RAM slave.
package ahb_blockram_if_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY = 1'b0;

    // Little-endian lane enables; any size above a word is treated as a word.
    function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << addr_lo;
            HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_blockram_fwd.sv
// One-entry write-forwarding buffer: merges the last written lanes over the RAM
// read data when a read follows a write to the same word with no gap.
module ahb_blockram_fwd (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cap_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wbe_i,
    input  logic        hit_i,
    input  logic        rd_phase_i,
    input  logic [31:0] ram_doutb_i,
    output logic [31:0] hrdata_o
);

    logic [31:0] fwd_data_q, fwd_data_d;
    logic [3:0]  fwd_be_q, fwd_be_d;
    logic        fwd_hit_q, fwd_hit_d;
    logic [3:0]  lane_sel;

    always_comb begin
        fwd_data_d = fwd_data_q;
        fwd_be_d   = fwd_be_q;
        fwd_hit_d  = hit_i;
        if (cap_i) begin
            fwd_data_d = wdata_i;
            fwd_be_d   = wbe_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
            fwd_hit_q  <= 1'b0;
        end else begin
            fwd_data_q <= fwd_data_d;
            fwd_be_q   <= fwd_be_d;
            fwd_hit_q  <= fwd_hit_d;
        end
    end

    assign lane_sel = fwd_be_q & {4{fwd_hit_q & rd_phase_i}};

    always_comb begin
        hrdata_o = ram_doutb_i;
        for (int i = 0; i < 4; i++) begin
            if (lane_sel[i]) hrdata_o[8*i +: 8] = fwd_data_q[8*i +: 8];
        end
    end

endmodule

// File: rtl/ahb_blockram_if.sv
// Zero-wait-state AHB-Lite slave in front of a dual-port block RAM: writes go out
// on port A in the data phase, reads go to port B in the address phase.
module ahb_blockram_if
    import ahb_blockram_if_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb
);

    logic                  acc;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [3:0]            req_be;
    logic                  wr_pend_q, wr_pend_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]            wr_be_q, wr_be_d;
    logic                  wr_cap;
    logic                  fwd_set;
    logic                  unused_ok;

    assign acc       = HSEL & HREADY & HTRANS[1];
    assign word_addr = HADDR[ADDR_WIDTH+1:2];
    assign req_be    = byte_enables(HSIZE, HADDR[1:0]);
    assign unused_ok = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    // Pipeline state only advances while the bus is ready, so a stalled bus
    // leaves the pending transfer untouched.
    always_comb begin
        wr_pend_d = wr_pend_q;
        rd_pend_d = rd_pend_q;
        wr_addr_d = wr_addr_q;
        wr_be_d   = wr_be_q;
        if (HREADY) begin
            wr_pend_d = acc & HWRITE;
            rd_pend_d = acc & ~HWRITE;
            if (acc & HWRITE) begin
                wr_addr_d = word_addr;
                wr_be_d   = req_be;
            end
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
        end else begin
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_be_q   <= wr_be_d;
        end
    end

    // A read accepted on the edge that commits a write to the same word would see
    // stale RAM data, so it is flagged for forwarding.
    assign wr_cap  = wr_pend_q & HREADY;
    assign fwd_set = wr_cap & acc & ~HWRITE & (word_addr == wr_addr_q);

    ahb_blockram_fwd u_fwd (
        .clk_i       (clka),
        .rst_i       (rst),
        .cap_i       (wr_cap),
        .wdata_i     (HWDATA),
        .wbe_i       (wr_be_q),
        .hit_i       (fwd_set),
        .rd_phase_i  (rd_pend_q),
        .ram_doutb_i (ram_doutb),
        .hrdata_o    (HRDATA)
    );

    assign HREADYOUT = 1'b1;
    assign HRESP     = HRESP_OKAY;
    assign ram_addra = wr_addr_q;
    assign ram_dina  = HWDATA;
    assign ram_wea   = wr_pend_q ? wr_be_q : 4'b0000;
    assign ram_addrb = word_addr;

endmodule

// File: tb/tb_ahb_blockram_if.sv
// Bench for ahb_blockram_if: attached RAM model, byte-array reference memory,
// directed scenarios and a randomized transfer stream.
module tb_ahb_blockram_if;
    import ahb_blockram_if_pkg::*;

    localparam int AW    = 12;
    localparam int WORDS = 1 << AW;

    logic          clka = 1'b0;
    logic          rst;
    logic          HSEL, HWRITE, HREADY;
    logic [31:0]   HADDR, HWDATA;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HREADYOUT, HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [31:0]   ram_dina, ram_doutb;
    logic [3:0]    ram_wea;

    logic [31:0]   ram [0:WORDS-1];
    logic [7:0]    ref_mem [0:4*WORDS-1];
    logic [31:0]   exp_q[$];

    int            n_checks = 0;
    int            n_fail = 0;
    logic          pend_w = 1'b0;
    logic          pend_r = 1'b0;
    logic [3:0]    pend_be = '0;
    int            pend_waddr = 0;
    logic [31:0]   pend_wdata = '0;
    logic [31:0]   last_rdata = '0;

    always #5 clka = ~clka;

    ahb_blockram_if #(.ADDR_WIDTH(AW)) dut (
        .clka(clka), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    // Read-first block RAM: port B returns the word as it was before this edge.
    always @(posedge clka) begin
        ram_doutb <= ram[ram_addrb];
        for (int i = 0; i < 4; i++)
            if (ram_wea[i]) ram[ram_addra][8*i +: 8] <= ram_dina[8*i +: 8];
    end

    function automatic logic [31:0] ref_word(input int wa);
        return {ref_mem[4*wa+3], ref_mem[4*wa+2], ref_mem[4*wa+1], ref_mem[4*wa]};
    endfunction

    // One bus cycle: new address phase plus the data phase of the previous transfer.
    task automatic step(input logic sel, input logic rdy, input logic [1:0] trans,
                        input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
        logic acc;
        logic [3:0] be;
        int wa, first, count;
        HSEL = sel; HREADY = rdy; HTRANS = trans; HWRITE = wr;
        HADDR = addr; HSIZE = size; HWDATA = pend_wdata;
        @(negedge clka);
        n_checks++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            n_fail++;
            $display("FAIL resp: HREADYOUT=%b HRESP=%b required 1/0", HREADYOUT, HRESP);
        end
        n_checks++;
        if (pend_w) begin
            if (ram_wea !== pend_be || ram_addra !== AW'(pend_waddr) || ram_dina !== pend_wdata) begin
                n_fail++;
                $display("FAIL wr_port: wea=%b addra=%h dina=%h required %b %h %h",
                         ram_wea, ram_addra, ram_dina, pend_be, AW'(pend_waddr), pend_wdata);
            end
        end else if (ram_wea !== 4'b0000) begin
            n_fail++;
            $display("FAIL wea_idle: wea=%b required 0000", ram_wea);
        end
        if (pend_r) begin
            logic [31:0] exp;
            exp = exp_q.pop_front();
            last_rdata = HRDATA;
            n_checks++;
            if (HRDATA !== exp) begin
                n_fail++;
                $display("FAIL hrdata: got %h required %h", HRDATA, exp);
            end
        end
        acc    = sel & rdy & trans[1];
        pend_w = acc & wr;
        pend_r = acc & ~wr;
        if (acc) begin
            wa = int'((addr >> 2) & 32'(WORDS - 1));
            if (wr) begin
                first = (size == 3'd0) ? int'(addr[1:0]) : (size == 3'd1) ? int'(addr[1:0]) & 2 : 0;
                count = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
                be = '0;
                for (int k = 0; k < count; k++) begin
                    be[first+k] = 1'b1;
                    ref_mem[4*wa + first + k] = wdata[8*(first+k) +: 8];
                end
                pend_be = be; pend_waddr = wa; pend_wdata = wdata;
            end else begin
                exp_q.push_back(ref_word(wa));
            end
        end
        @(posedge clka);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, $urandom);
    endtask

    task automatic test_reset;
        n_checks++;
        if (ram_wea !== 4'b0000 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: wea=%b hreadyout=%b hresp=%b required 0000 1 0", ram_wea, HREADYOUT, HRESP);
        end
    endtask

    task automatic test_word_write_read;
        step(1, 1, HTRANS_NONSEQ, 1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
        idle(2);
        step(1, 1, HTRANS_NONSEQ, 0, 32'h10, HSIZE_WORD, 32'h0);
        idle(1);
        n_checks++;
        if (last_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_rd: got %h required deadbeef", last_rdata);
        end
    endtask

    task automatic test_byte_lanes;
        step(1, 1, HTRANS_NONSEQ, 1, 32'h20, HSIZE_BYTE, 32'h11111111);
        step(1, 1, HTRANS_SEQ,    1, 32'h21, HSIZE_BYTE, 32'h22222222);
        step(1, 1, HTRANS_SEQ,    1, 32'h22, HSIZE_BYTE, 32'h33333333);
        step(1, 1, HTRANS_SEQ,    1, 32'h23, HSIZE_BYTE, 32'h44444444);
        step(1, 1, HTRANS_NONSEQ, 0, 32'h20, HSIZE_WORD, 32'h0);
        idle(1);
        n_checks++;
        if (last_rdata !== 32'h44332211) begin
            n_fail++;
            $display("FAIL byte_rd: got %h required 44332211", last_rdata);
        end
    endtask

    task automatic test_forward_hit;
        step(1, 1, HTRANS_NONSEQ, 1, 32'h30, HSIZE_WORD, 32'h00000000);
        idle(2);
        step(1, 1, HTRANS_NONSEQ, 1, 32'h32, HSIZE_HALF, 32'hABCDABCD);
        step(1, 1, HTRANS_NONSEQ, 0, 32'h30, HSIZE_WORD, 32'h0);
        idle(1);
        n_checks++;
        if (last_rdata !== 32'hABCD0000) begin
            n_fail++;
            $display("FAIL fwd_rd: got %h required abcd0000", last_rdata);
        end
    endtask

    task automatic test_no_forward_adjacent;
        logic [31:0] prior;
        prior = ref_word(32'h44 >> 2);
        step(1, 1, HTRANS_NONSEQ, 1, 32'h40, HSIZE_WORD, $urandom);
        step(1, 1, HTRANS_NONSEQ, 0, 32'h44, HSIZE_WORD, 32'h0);
        idle(1);
        n_checks++;
        if (last_rdata !== prior) begin
            n_fail++;
            $display("FAIL adj_rd: got %h required %h", last_rdata, prior);
        end
    endtask

    task automatic test_no_accept;
        logic [31:0] prior;
        prior = ref_word(32'h60 >> 2);
        step(1, 1, HTRANS_BUSY,   1, 32'h60, HSIZE_WORD, 32'h12345678);
        step(0, 1, HTRANS_NONSEQ, 1, 32'h60, HSIZE_WORD, 32'h9ABCDEF0);
        step(1, 0, HTRANS_NONSEQ, 1, 32'h60, HSIZE_WORD, 32'h0F0F0F0F);
        idle(1);
        step(1, 1, HTRANS_NONSEQ, 0, 32'h60, HSIZE_WORD, 32'h0);
        idle(1);
        n_checks++;
        if (last_rdata !== prior) begin
            n_fail++;
            $display("FAIL noacc_rd: got %h required %h", last_rdata, prior);
        end
    endtask

    task automatic test_reset_mid_write;
        logic [31:0] prior;
        prior = ref_word(32'h50 >> 2);
        step(1, 1, HTRANS_NONSEQ, 1, 32'h50, HSIZE_WORD, 32'hCAFEF00D);
        HSEL = 0; HTRANS = HTRANS_IDLE; HWDATA = pend_wdata;
        #1;
        n_checks++;
        if (ram_wea !== 4'b1111) begin
            n_fail++;
            $display("FAIL rst_pre: wea=%b required 1111", ram_wea);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (ram_wea !== 4'b0000 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: wea=%b hreadyout=%b hresp=%b required 0000 1 0", ram_wea, HREADYOUT, HRESP);
        end
        pend_w = 1'b0; pend_r = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[4*(32'h50 >> 2) + i] = prior[8*i +: 8];
        @(posedge clka);
        #2 rst = 1'b0;
        @(posedge clka);
        #1;
        step(1, 1, HTRANS_NONSEQ, 0, 32'h50, HSIZE_WORD, 32'h0);
        idle(1);
        n_checks++;
        if (last_rdata !== prior) begin
            n_fail++;
            $display("FAIL rst_rd: got %h required %h", last_rdata, prior);
        end
    endtask

    task automatic test_random;
        logic sel, rdy, wr;
        logic [1:0] trans;
        logic [2:0] size;
        logic [31:0] addr;
        for (int n = 0; n < 400; n++) begin
            sel   = ($urandom_range(0, 7) != 0);
            rdy   = (pend_w || pend_r) ? 1'b1 : ($urandom_range(0, 7) != 0);
            trans = 2'($urandom_range(0, 3));
            wr    = 1'($urandom_range(0, 1));
            size  = 3'($urandom_range(0, 3));
            addr  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 47));
            step(sel, rdy, trans, wr, addr, size, $urandom);
        end
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = ram[i][8*b +: 8];
        end
        ram_doutb = '0;
        rst = 1'b1;
        HSEL = 0; HREADY = 1; HTRANS = HTRANS_IDLE; HWRITE = 0;
        HADDR = '0; HSIZE = HSIZE_WORD; HWDATA = '0;
        repeat (2) @(posedge clka);
        #1;
        test_reset;
        @(negedge clka) rst = 1'b0;
        @(posedge clka);
        #1;
        test_word_write_read;
        test_byte_lanes;
        test_forward_hit;
        test_no_forward_adjacent;
        test_no_accept;
        test_reset_mid_write;
        test_random;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d reads left in queue required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_blockram_if.md
Name: ahb_blockram_if

Overview:
AHB-Lite slave front end for the dual-port block RAM used as on-chip code/data memory of the Cortex-M0 SoC. It decodes AHB transfers, drives the RAM write port (addra/dina/wea) in the write data phase and the RAM read port (addrb) in the read address phase, then returns doutb as HRDATA. It runs with zero wait states and includes a one-entry write-forwarding buffer, so a read issued immediately after a write to the same word returns the new data.

Parameters:
ADDR_WIDTH, 12, word-address width of the attached RAM (capacity 4*2**ADDR_WIDTH bytes)

Ports:
clka  input  1  single clock for AHB and RAM; all flops on the rising edge
rst  input  1  asynchronous, active-high reset
HSEL  input  1  slave select from address decoder
HADDR  input  32  AHB byte address
HTRANS  input  2  transfer type; bit1=1 means NONSEQ/SEQ
HSIZE  input  3  0=byte, 1=half, 2=word; values >2 are treated as word
HWRITE  input  1  1=write
HWDATA  input  32  write data (data phase)
HREADY  input  1  bus-wide ready
HREADYOUT  output  1  slave ready; constant 1
HRESP  output  1  constant 0 (OKAY)
HRDATA  output  32  read data (data phase)
ram_addra  output  ADDR_WIDTH  RAM write word address
ram_dina  output  32  RAM write data
ram_wea  output  4  RAM byte write enables
ram_addrb  output  ADDR_WIDTH  RAM read word address
ram_doutb  input  32  RAM registered read data (1-cycle latency)

Behaviour:
- Transfer accept: acc = HSEL & HREADY & HTRANS[1]. IDLE/BUSY, HSEL=0 or HREADY=0 -> no accept and no state change.
- Word address = HADDR[ADDR_WIDTH+1:2]. Upper address bits are ignored; addresses wrap modulo RAM size.
- Byte enables (little-endian) from HSIZE and HADDR[1:0]:
  - byte: 1<<HADDR[1:0]
  - half: HADDR[1]?4'b1100:4'b0011 (HADDR[0] ignored)
  - word: 4'b1111 (HADDR[1:0] ignored)
- Write: on an accepted write, register wr_pend=1, wr_addr and wr_be. In the following (data) cycle: ram_addra=wr_addr, ram_dina=HWDATA, ram_wea=wr_be if wr_pend, else ram_wea=0. The RAM commits at the end of the data phase. wr_pend clears on the next edge unless a new write is accepted.
- Read: ram_addrb = HADDR word address combinationally in every cycle. On an accepted read, register rd_pend=1. In the data phase, HRDATA = ram_doutb (1-cycle latency, zero wait state).
- Forwarding:
  - At the edge that ends a write data phase, capture fwd_data=HWDATA, fwd_be=wr_be.
  - At that same edge, if a read is accepted with a word address equal to wr_addr, set fwd_hit=1.
  - In the read data phase, HRDATA byte i = fwd_be[i]&fwd_hit ? fwd_data byte i : ram_doutb byte i.
  - fwd_hit clears on every edge that does not set it.
  - Reads more than one cycle after the write need no forwarding.
- Back-to-back write->write and read->write need no extra handling; each write uses its own data phase.
- HRDATA outside a read data phase: ram_doutb (don't-care to the bus; no X injection required).
- Reset (asynchronous, any time, including mid data phase): wr_pend=0, rd_pend=0, fwd_hit=0, fwd_be=0, wr_addr=0, fwd_data=0. ram_wea=0 immediately, so an in-flight write is dropped. HREADYOUT=1 and HRESP=0 during and after reset.

Decomposition:
- Shared package: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HSIZE encodings, a byte-enable decode function, and an OKAY response constant.
- One natural sub-module: ahb_blockram_fwd. It holds the forwarding register and the byte merge: inputs are the write-capture signals, the address compare result, ram_doutb and fwd data; output is HRDATA.
- Everything else stays in the top module.

Test Plan:
- Word write 0xDEADBEEF at 0x10, IDLE for 2 cycles, then read 0x10 -> ram_wea=1111 and ram_addra=4 in the data phase; HRDATA=0xDEADBEEF.
- Byte writes 0x11 @0x20, 0x22 @0x21, 0x33 @0x22, 0x44 @0x23 (HWDATA lanes replicated), then word read 0x20 -> wea sequence 0001, 0010, 0100, 1000; HRDATA=0x44332211.
- Word 0x00000000 @0x30 previously written; halfword write 0xABCD @0x32, immediately followed by a word read @0x30 (no gap) -> forwarding hit; HRDATA=0xABCD0000.
- Write @0x40 then read @0x44 back-to-back -> no forward hit; HRDATA equals the prior content of 0x44 from RAM.
- HTRANS=BUSY or HSEL=0 or HREADY=0 with HWRITE=1 -> ram_wea stays 0 the next cycle; no state change.
- rst asserted asynchronously mid write data phase -> ram_wea drops to 0 without waiting for an edge; the RAM word is unchanged; after release a read returns the old value and HREADYOUT=1 throughout.
